// File: rtl/period_meter_pkg.sv
`default_nettype none
// ============================================================================
// period_meter_pkg : state encoding and default timing constants for period_meter
// Rev 1.0
// ============================================================================
package period_meter_pkg;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      TIMEOUT    = 2'd2
   } state_t;

   localparam int unsigned CLK_HZ          = 100_000_000;
   localparam int unsigned DEF_EXP_PERIOD  = CLK_HZ / 10;
   localparam int unsigned DEF_TOL         = 1_000;
   localparam int unsigned DEF_TIMEOUT_CYC = 12_000_000;
   localparam int unsigned DEF_LOCK_CNT    = 3;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// sync_edge_det : two-flop synchroniser plus history flop, rising-edge pulse out
// Rev 1.0
// ============================================================================
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// period_meter : measures clk cycles between rising edges of a slow input
// Rev 1.0
// ============================================================================
module period_meter
   import period_meter_pkg::*;
#(
   parameter int          CNT_W       = 24,
   parameter int unsigned EXP_PERIOD  = DEF_EXP_PERIOD,
   parameter int unsigned TOL         = DEF_TOL,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             in_range,
   output logic             locked,
   output logic             timeout
);

   localparam int LOCK_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

   // Lower bound clamps at zero so the window test stays purely unsigned.
   localparam logic [31:0]       LO_BOUND = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 32'd0;
   localparam logic [31:0]       HI_BOUND = EXP_PERIOD + TOL;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [CNT_W-1:0]   cnt_p1;
   logic [31:0]        cnt_ext;
   logic               rise;
   logic               at_max;
   logic               meas;
   logic               in_range_c;
   logic [LOCK_W-1:0]  lock_ctr;
   logic [LOCK_W-1:0]  lock_ctr_inc;

   sync_edge_det u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sig_in),
      .rise  (rise)
   );

   assign cnt_p1       = cnt + CNT_W'(1);
   assign cnt_ext      = 32'(cnt_p1);
   assign at_max       = (cnt == CNT_MAX);
   assign in_range_c   = (cnt_ext >= LO_BOUND) && (cnt_ext <= HI_BOUND);
   assign lock_ctr_inc = (lock_ctr == LOCK_MAX) ? lock_ctr : lock_ctr + LOCK_W'(1);

   // A rise always takes priority over the timeout boundary.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      meas      = 1'b0;
      case (state)
         WAIT_FIRST: begin
            if (rise) begin
               state_nxt = MEASURE;
               cnt_nxt   = '0;
            end else if (at_max) begin
               state_nxt = TIMEOUT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt_p1;
            end
         end
         MEASURE: begin
            if (rise) begin
               meas      = 1'b1;
               cnt_nxt   = '0;
            end else if (at_max) begin
               state_nxt = TIMEOUT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt_p1;
            end
         end
         TIMEOUT: begin
            cnt_nxt = '0;
            if (rise) begin
               state_nxt = MEASURE;
            end
         end
         default: begin
            state_nxt = WAIT_FIRST;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= WAIT_FIRST;
         cnt        <= '0;
         period     <= '0;
         period_vld <= 1'b0;
         in_range   <= 1'b0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
         lock_ctr   <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         period_vld <= meas;
         timeout    <= (state_nxt == TIMEOUT);
         if (meas) begin
            period   <= cnt_p1;
            in_range <= in_range_c;
            if (in_range_c) begin
               lock_ctr <= lock_ctr_inc;
               locked   <= (lock_ctr_inc == LOCK_MAX);
            end else begin
               lock_ctr <= '0;
               locked   <= 1'b0;
            end
         end else if (state_nxt == TIMEOUT) begin
            lock_ctr <= '0;
            locked   <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// tb_period_meter : directed table-driven bench for period_meter
// Rev 1.0
// ============================================================================
module tb_period_meter;

   localparam int CNT_W = 8;

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b1;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period;
   logic             period_vld;
   logic             in_range;
   logic             locked;
   logic             timeout;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   period_meter #(
      .CNT_W       (CNT_W),
      .EXP_PERIOD  (20),
      .TOL         (2),
      .TIMEOUT_CYC (50),
      .LOCK_CNT    (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in),
      .period     (period),
      .period_vld (period_vld),
      .in_range   (in_range),
      .locked     (locked),
      .timeout    (timeout)
   );

   // rst: reset before pulsing; gap: cycles until next sig_in rise;
   // expectations refer to the strobe caused by this row's rising edge.
   typedef struct {
      logic rst;
      int   gap;
      logic vld;
      int   per;
      logic ir;
      logic lk;
   } vec_t;

   vec_t tbl [22];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input int idx);
      vec_t v;
      int   nv;
      int   nto;
      int   vld3;
      int   p3;
      int   ir3;
      int   lk3;
      v    = tbl[idx];
      nv   = 0;
      nto  = 0;
      vld3 = -1;
      p3   = -1;
      ir3  = -1;
      lk3  = -1;
      if (v.rst) begin
         sig_in = 1'b0;
         rst_n  = 1'b1;
         repeat (2) @(negedge clk);
         rst_n  = 1'b0;
      end
      sig_in = 1'b1;
      for (int i = 1; i <= v.gap; i++) begin
         @(negedge clk);
         if (i == 5) sig_in = 1'b0;
         if (period_vld) nv++;
         if (i >= 3 && timeout) nto++;
         if (i == 3) begin
            vld3 = int'(period_vld);
            p3   = int'(period);
            ir3  = int'(in_range);
            lk3  = int'(locked);
         end
      end
      chk($sformatf("row%0d vld_at_3", idx), vld3, int'(v.vld));
      chk($sformatf("row%0d vld_count", idx), nv, int'(v.vld));
      chk($sformatf("row%0d period", idx), p3, v.per);
      chk($sformatf("row%0d in_range", idx), ir3, int'(v.ir));
      chk($sformatf("row%0d locked", idx), lk3, int'(v.lk));
      chk($sformatf("row%0d timeout_cycles", idx), nto, 0);
   endtask

   initial begin
      int first;
      int lk_at;
      int per_at;
      int ir_at;

      // Five edges 20 apart: reference edge, then four strobes.
      tbl[0]  = '{1'b1, 20, 1'b0,  0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 20, 1'b1, 20, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 20, 1'b1, 20, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 20, 1'b1, 20, 1'b1, 1'b1};
      tbl[4]  = '{1'b0,  6, 1'b1, 20, 1'b1, 1'b1};
      // 20, 20, 25 breaks the lock run; three 19s rebuild it.
      tbl[5]  = '{1'b1, 20, 1'b0,  0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 20, 1'b1, 20, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 25, 1'b1, 20, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 19, 1'b1, 25, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 19, 1'b1, 19, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 19, 1'b1, 19, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 18, 1'b1, 19, 1'b1, 1'b1};
      // Window edges 18/22 inside, 17/23 outside.
      tbl[12] = '{1'b0, 22, 1'b1, 18, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 17, 1'b1, 22, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 23, 1'b1, 17, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 20, 1'b1, 23, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 20, 1'b1, 20, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 20, 1'b1, 20, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 10, 1'b1, 20, 1'b1, 1'b1};
      // After timeout: reference edge, a 20 period, then a 50 period.
      tbl[19] = '{1'b0, 20, 1'b0, 20, 1'b1, 1'b0};
      tbl[20] = '{1'b0, 50, 1'b1, 20, 1'b1, 1'b0};
      tbl[21] = '{1'b0,  6, 1'b1, 50, 1'b0, 1'b0};

      // Reset pulse mid-count, then idle until timeout.
      rst_n  = 1'b1;
      sig_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("reset period", int'(period), 0);
      chk("reset period_vld", int'(period_vld), 0);
      chk("reset in_range", int'(in_range), 0);
      chk("reset locked", int'(locked), 0);
      chk("reset timeout", int'(timeout), 0);
      @(negedge clk);
      rst_n = 1'b0;
      first = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (timeout && first < 0) first = k;
      end
      chk("idle timeout cycle", first, 50);

      for (int r = 0; r <= 18; r++) apply(r);

      // Input stops after lock: expect timeout 50 cycles after the last rise.
      first  = -1;
      lk_at  = -1;
      per_at = -1;
      ir_at  = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (timeout && first < 0) begin
            first  = k;
            lk_at  = int'(locked);
            per_at = int'(period);
            ir_at  = int'(in_range);
         end
      end
      chk("stop timeout cycle", first, 43);
      chk("stop locked", lk_at, 0);
      chk("stop period hold", per_at, 20);
      chk("stop in_range hold", ir_at, 1);

      for (int r = 19; r <= 21; r++) apply(r);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of a slow external square wave, such as a divided 10 Hz tick or off-chip beacon, in cycles of the 100 MHz system clock.
- Synchronises and edge-detects the input, then counts clk cycles between consecutive rising edges.
- Reports each measurement with a one-cycle valid strobe.
- Flags in-range, locked and timeout status for the status/LED logic.

Parameters:
- CNT_W, 24, width of period counter and period output; must hold TIMEOUT_CYC.
- EXP_PERIOD, 10_000_000, expected period in clk cycles (100 MHz / 10 Hz).
- TOL, 1_000, allowed absolute deviation from EXP_PERIOD for in-range.
- TIMEOUT_CYC, 12_000_000, cycles without a rising edge before declaring timeout.
- LOCK_CNT, 3, consecutive in-range measurements required to assert locked.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous reset, active-high.
- sig_in  in  1  asynchronous input signal to be measured.
- period  out  CNT_W  last measured period in clk cycles.
- period_vld  out  1  one-cycle strobe when period updates.
- in_range  out  1  last period within EXP_PERIOD ± TOL.
- locked  out  1  LOCK_CNT consecutive in-range measurements seen.
- timeout  out  1  no rising edge for TIMEOUT_CYC cycles.

Behaviour:
- Reset is rst_n, asynchronous, active-high; clock is clk. While rst_n=1:
  - all flops clear: period=0, period_vld=0, in_range=0, locked=0, timeout=0;
  - state=WAIT_FIRST, cnt=0, lock_ctr=0.
- Sync and edge detect:
  - sig_in passes through 2 synchroniser flops plus one history flop.
  - rise = s2 & ~s3.
  - A sig_in rising transition produces rise 2-3 clk later.
- cnt advances by 1 per clk in MEASURE and WAIT_FIRST, and never exceeds TIMEOUT_CYC-1.
- FSM states:
  - WAIT_FIRST:
    - rise -> MEASURE, cnt<=0, no period_vld.
    - cnt==TIMEOUT_CYC-1 -> TIMEOUT.
  - MEASURE:
    - rise -> period<=cnt+1, period_vld<=1 next cycle, cnt<=0, stay in MEASURE.
    - cnt==TIMEOUT_CYC-1 with no rise -> TIMEOUT.
  - TIMEOUT:
    - timeout=1, locked<=0, lock_ctr<=0; in_range and period hold their last values.
    - rise -> MEASURE, cnt<=0, timeout<=0, no period_vld; this first edge is a reference edge only.
- Simultaneous rise and cnt==TIMEOUT_CYC-1 in MEASURE: rise wins, and the measurement period=TIMEOUT_CYC is reported.
- Latency: period, in_range and period_vld all update on the same clk edge, one cycle after the rise cycle.
  - in_range is computed combinationally from cnt+1, as |cnt+1-EXP_PERIOD| <= TOL, using unsigned compare of both bounds with no signed arithmetic.
- Lock, evaluated on each measurement:
  - In range: lock_ctr increments, saturating at LOCK_CNT.
  - Out of range: lock_ctr<=0 and locked<=0.
  - locked<=1 when lock_ctr reaches LOCK_CNT; locked is registered in the same cycle as period_vld.
- period_vld is exactly one cycle wide and never asserts in WAIT_FIRST or TIMEOUT.
- Reset asserted mid-measurement discards the partial count; after release the block restarts in WAIT_FIRST.

Decomposition:
- Shared package holds:
  - state enum (WAIT_FIRST, MEASURE, TIMEOUT);
  - default constants CLK_HZ=100_000_000, EXP_PERIOD, TOL, TIMEOUT_CYC.
- One sub-module, sync_edge_det:
  - 2-FF synchroniser plus history flop, output rise;
  - same asynchronous active-high reset;
  - reusable for buttons and other slow inputs.

Test Plan (bench parameters: EXP_PERIOD=20, TOL=2, TIMEOUT_CYC=50, LOCK_CNT=3, CNT_W=8):
- Reset pulse mid-count, then idle: all outputs 0 after reset; with sig_in held at 0, timeout=1 exactly 50 cycles after reset release.
- sig_in rising every 20 clk for 5 edges:
  - no period_vld on the first edge;
  - then 4 strobes with period=20 and in_range=1;
  - locked=1 coincident with the 3rd strobe and held on the 4th.
- Steady periods 20, 20, then one of 25: in_range=0 with period=25; locked stays 0; lock_ctr restarts so three further periods of 19 are needed, and locked=1 on the third.
- Boundaries:
  - periods 18 and 22 -> in_range=1;
  - periods 17 and 23 -> in_range=0.
- Locked, then sig_in stops:
  - 50 cycles after the last rise, timeout=1 and locked=0, with period holding 20;
  - the next rise clears timeout with no strobe;
  - the following rise 20 cycles later gives period=20 and period_vld=1.
- Edge exactly at timeout: rises spaced 50 clk -> period_vld with period=50, in_range=0, timeout stays 0.
